// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder.
package spi_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_e;

    function automatic logic sample_on_rise(input logic ckp, input logic cph);
        return ckp == cph;
    endfunction

endpackage

// File: rtl/spi_receiver_if.sv
// Serial bus lines between an SPI master and the responder.
interface spi_receiver_if;

    logic SCK;
    logic CS;
    logic MOSI;
    logic MISO;

    modport master (output SCK, output CS, output MOSI, input MISO);
    modport slave  (input SCK, input CS, input MOSI, output MISO);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous line with registered edge pulses.
module spi_sync_edge #(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                prev_q, prev_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STG-2:0], d};
        prev_d = sync_q[SYNC_STG-1];
        rise_d = sync_q[SYNC_STG-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STG-1] & prev_q;
    end

    // Reset to the line's idle level so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STG{init}};
            prev_q <= init;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_receiver.sv
// SPI responder: oversamples SCK/CS/MOSI in the CLK domain, receives and replies
// with WORD_W-bit frames in any CKP/CPH mode.
module spi_receiver
    import spi_pkg::*;
#(
    parameter int unsigned       SYNC_STG   = 2,
    parameter logic [WORD_W-1:0] IDLE_REPLY = 16'h0062
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CKP,
    input  logic              CPH,
    spi_receiver_if.slave     spi,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_e              state_q, state_d;
    logic                ckp_q, ckp_d, cph_q, cph_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [WORD_W-2:0]   shift_rx_q, shift_rx_d;
    logic [WORD_W-1:0]   shift_tx_q, shift_tx_d;
    logic [WORD_W-1:0]   reply_q, reply_d;
    logic [WORD_W-1:0]   rx_data_q, rx_data_d;
    logic                pending_q, pending_d;
    logic                started_q, started_d;
    logic                miso_q, miso_d;
    logic                rx_valid_q, rx_valid_d;
    logic                frame_err_q, frame_err_d;
    logic [SYNC_STG-1:0] mosi_sync_q, mosi_sync_d;

    logic              sck_rise, sck_fall, cs_rise, cs_fall;
    logic              mosi_s, sample, drive, word_done;
    logic [WORD_W-1:0] reply_next;

    spi_sync_edge #(.SYNC_STG(SYNC_STG)) u_sck_sync (
        .clk(CLK), .rst_n(RESET), .init(CKP), .d(spi.SCK), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.SYNC_STG(SYNC_STG)) u_cs_sync (
        .clk(CLK), .rst_n(RESET), .init(1'b1), .d(spi.CS), .rise(cs_rise), .fall(cs_fall)
    );

    assign mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], spi.MOSI};
    assign mosi_s      = mosi_sync_q[SYNC_STG-1];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = LOAD;
            LOAD:    state_d = cs_rise ? IDLE : SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sample      = sample_on_rise(ckp_q, cph_q) ? sck_rise : sck_fall;
        drive       = sample_on_rise(ckp_q, cph_q) ? sck_fall : sck_rise;
        word_done   = (state_q == SHIFT) && sample && (bitcnt_q == LAST_BIT);
        reply_next  = pending_q ? reply_q : IDLE_REPLY;

        ckp_d       = ckp_q;
        cph_d       = cph_q;
        bitcnt_d    = bitcnt_q;
        shift_rx_d  = shift_rx_q;
        shift_tx_d  = shift_tx_q;
        reply_d     = reply_q;
        rx_data_d   = rx_data_q;
        pending_d   = pending_q;
        started_d   = started_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (tx_load) reply_d = tx_data;
                if (cs_fall) begin
                    ckp_d = CKP;
                    cph_d = CPH;
                end
            end
            LOAD: begin
                bitcnt_d  = '0;
                started_d = 1'b0;
                pending_d = tx_load;
                if (tx_load) reply_d = tx_data;
                // CPH=0 presents the MSB now; the remaining bits go out on drive edges.
                if (!cph_q) begin
                    miso_d     = reply_q[WORD_W-1];
                    shift_tx_d = {reply_q[WORD_W-2:0], 1'b0};
                end else begin
                    shift_tx_d = reply_q;
                end
            end
            SHIFT: begin
                if (drive && (cph_q || started_q)) begin
                    miso_d     = shift_tx_q[WORD_W-1];
                    shift_tx_d = {shift_tx_q[WORD_W-2:0], 1'b0};
                end
                if (sample) begin
                    started_d  = 1'b1;
                    shift_rx_d = {shift_rx_q[WORD_W-3:0], mosi_s};
                    if (word_done) begin
                        rx_data_d  = {shift_rx_q, mosi_s};
                        rx_valid_d = 1'b1;
                        bitcnt_d   = '0;
                        reply_d    = reply_next;
                        pending_d  = 1'b0;
                        shift_tx_d = reply_next;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                if (tx_load) begin
                    reply_d   = tx_data;
                    pending_d = 1'b1;
                end
                if (cs_rise) begin
                    miso_d      = 1'b0;
                    frame_err_d = word_done ? 1'b0 : (sample || (bitcnt_q != '0));
                end
            end
            default: miso_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ckp_q       <= 1'b0;
            cph_q       <= 1'b0;
            bitcnt_q    <= '0;
            shift_rx_q  <= '0;
            shift_tx_q  <= '0;
            reply_q     <= IDLE_REPLY;
            rx_data_q   <= '0;
            pending_q   <= 1'b0;
            started_q   <= 1'b0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            mosi_sync_q <= '0;
        end else begin
            ckp_q       <= ckp_d;
            cph_q       <= cph_d;
            bitcnt_q    <= bitcnt_d;
            shift_rx_q  <= shift_rx_d;
            shift_tx_q  <= shift_tx_d;
            reply_q     <= reply_d;
            rx_data_q   <= rx_data_d;
            pending_q   <= pending_d;
            started_q   <= started_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign spi.MISO  = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_receiver.sv
// Bench for spi_receiver: behavioural SPI master plus an rx_data scoreboard.
module tb_spi_receiver;

    localparam int unsigned HALF       = 8;
    localparam logic [15:0] IDLE_REPLY = 16'h0062;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        CKP = 1'b0;
    logic        CPH = 1'b0;
    logic        tx_load = 1'b0;
    logic [15:0] tx_data = '0;
    logic [15:0] rx_data;
    logic        rx_valid, frame_err, busy;

    spi_receiver_if bus ();

    spi_receiver #(.SYNC_STG(2), .IDLE_REPLY(IDLE_REPLY)) dut (
        .CLK(CLK), .RESET(RESET), .CKP(CKP), .CPH(CPH), .spi(bus),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int unsigned n_assert = 0, n_fail = 0;
    int unsigned rv_cnt = 0, fe_cnt = 0, cyc = 0, rv_cyc_last = 0, rv_cyc_prev = 0;
    int unsigned rv0, fe0;
    logic [15:0] exp_rx_q[$];
    logic [15:0] exp_w;
    logic [31:0] rxw;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: every rx_valid cycle consumes one expected word.
    always @(negedge CLK) begin
        if (frame_err) fe_cnt++;
        if (rx_valid) begin
            rv_cnt++;
            rv_cyc_prev = rv_cyc_last;
            rv_cyc_last = cyc;
            n_assert++;
            if (exp_rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_scoreboard: rx_data=%h arrived, no word expected", rx_data);
            end else begin
                exp_w = exp_rx_q.pop_front();
                if (rx_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL rx_scoreboard: rx_data=%h expected %h", rx_data, exp_w);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_mode(input logic ckp, input logic cph);
        RESET    = 1'b0;
        CKP      = ckp;
        CPH      = cph;
        bus.SCK  = ckp;
        bus.CS   = 1'b1;
        bus.MOSI = 1'b0;
        wait_clk(3);
        RESET = 1'b1;
        wait_clk(3);
    endtask

    task automatic pulse_load(input logic [15:0] d);
        @(negedge CLK);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge CLK);
        tx_load = 1'b0;
    endtask

    // Master: bits leave from tx[31] downward; captured MISO bits shift in at rx[0].
    task automatic spi_frame(input logic [31:0] tx, input int unsigned nbits,
                             input bit raise, output logic [31:0] rx);
        logic [31:0] sh;
        sh = tx;
        rx = '0;
        bus.CS = 1'b0;
        if (!CPH) begin
            bus.MOSI = sh[31];
            sh = sh << 1;
        end
        wait_clk(HALF);
        for (int unsigned i = 0; i < nbits; i++) begin
            if (CPH) begin
                bus.SCK  = ~bus.SCK;
                bus.MOSI = sh[31];
                sh = sh << 1;
                wait_clk(HALF);
                rx = {rx[30:0], bus.MISO};
                bus.SCK = ~bus.SCK;
                wait_clk(HALF);
            end else begin
                rx = {rx[30:0], bus.MISO};
                bus.SCK = ~bus.SCK;
                wait_clk(HALF);
                bus.SCK  = ~bus.SCK;
                bus.MOSI = sh[31];
                sh = sh << 1;
                wait_clk(HALF);
            end
        end
        if (raise) begin
            bus.CS   = 1'b1;
            bus.MOSI = 1'b0;
            wait_clk(2 * HALF);
        end
    endtask

    task automatic test_reset;
        bus.SCK = 1'b0; bus.CS = 1'b1; bus.MOSI = 1'b0;
        wait_clk(3);
        n_assert++;
        if ({rx_data, rx_valid, frame_err, busy, bus.MISO} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 00000",
                     {rx_data, rx_valid, frame_err, busy, bus.MISO});
        end
        RESET = 1'b1;
        wait_clk(5);
        n_assert++;
        if ({busy, bus.MISO, rx_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: busy/miso/rx_valid=%b expected 000", {busy, bus.MISO, rx_valid});
        end
    endtask

    task automatic test_modes;
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0]);
            pulse_load(16'h0062);
            rv0 = rv_cnt; fe0 = fe_cnt;
            exp_rx_q.push_back(16'h0015);
            spi_frame({16'h0015, 16'h0000}, 16, 1'b1, rxw);
            n_assert++;
            if (rxw[15:0] !== 16'h0062) begin
                n_fail++;
                $display("FAIL mode%0d_miso: got %h expected 0062", m, rxw[15:0]);
            end
            n_assert++;
            if (rv_cnt - rv0 !== 1) begin
                n_fail++;
                $display("FAIL mode%0d_rx_valid_cycles: got %0d expected 1", m, rv_cnt - rv0);
            end
            n_assert++;
            if (rx_data !== 16'h0015 || fe_cnt !== fe0) begin
                n_fail++;
                $display("FAIL mode%0d_rx_data: got %h err=%0d expected 0015 err=0", m, rx_data, fe_cnt - fe0);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int p = 0; p < 2; p++) begin
            set_mode(1'b0, p[0]);
            pulse_load(16'hC3F0);
            rv0 = rv_cnt;
            exp_rx_q.push_back(16'hA5A5);
            exp_rx_q.push_back(16'h5A5A);
            spi_frame({16'hA5A5, 16'h5A5A}, 32, 1'b1, rxw);
            n_assert++;
            if (rxw !== {16'hC3F0, IDLE_REPLY}) begin
                n_fail++;
                $display("FAIL b2b_cph%0d_miso: got %h expected c3f00062", p, rxw);
            end
            n_assert++;
            if (rv_cnt - rv0 !== 2) begin
                n_fail++;
                $display("FAIL b2b_cph%0d_pulses: got %0d expected 2", p, rv_cnt - rv0);
            end
            n_assert++;
            if (rv_cyc_last - rv_cyc_prev !== 32 * HALF) begin
                n_fail++;
                $display("FAIL b2b_cph%0d_spacing: got %0d cycles expected %0d", p,
                         rv_cyc_last - rv_cyc_prev, 32 * HALF);
            end
        end
    endtask

    task automatic test_frame_err;
        rv0 = rv_cnt; fe0 = fe_cnt;
        spi_frame({16'hB7B7, 16'h0000}, 7, 1'b1, rxw);
        n_assert++;
        if (fe_cnt - fe0 !== 1) begin
            n_fail++;
            $display("FAIL frame_err_pulse: got %0d cycles expected 1", fe_cnt - fe0);
        end
        n_assert++;
        if (rv_cnt !== rv0 || rx_data !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL frame_err_rx_hold: rx_data=%h pulses=%0d expected 5a5a 0", rx_data, rv_cnt - rv0);
        end
        fe0 = fe_cnt;
        exp_rx_q.push_back(16'h3C96);
        spi_frame({16'h3C96, 16'h0000}, 16, 1'b1, rxw);
        n_assert++;
        if (rx_data !== 16'h3C96 || rxw[15:0] !== IDLE_REPLY || fe_cnt !== fe0) begin
            n_fail++;
            $display("FAIL frame_err_recover: rx=%h miso=%h err=%0d expected 3c96 0062 0",
                     rx_data, rxw[15:0], fe_cnt - fe0);
        end
    endtask

    task automatic test_reset_mid_frame;
        set_mode(1'b1, 1'b1);
        rv0 = rv_cnt; fe0 = fe_cnt;
        spi_frame({16'hBEEF, 16'h0000}, 9, 1'b0, rxw);
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy: got %b expected 1", busy);
        end
        RESET = 1'b0;
        #1;
        n_assert++;
        if ({rx_data, rx_valid, frame_err, busy, bus.MISO} !== 20'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 00000",
                     {rx_data, rx_valid, frame_err, busy, bus.MISO});
        end
        bus.CS = 1'b1; bus.SCK = CKP; bus.MOSI = 1'b0;
        wait_clk(4);
        RESET = 1'b1;
        wait_clk(4);
        n_assert++;
        if (rv_cnt !== rv0 || fe_cnt !== fe0) begin
            n_fail++;
            $display("FAIL midreset_no_pulse: rx_valid=%0d frame_err=%0d expected 0 0", rv_cnt - rv0, fe_cnt - fe0);
        end
        exp_rx_q.push_back(16'hFFFF);
        spi_frame({16'hFFFF, 16'h0000}, 16, 1'b1, rxw);
        n_assert++;
        if (rx_data !== 16'hFFFF || rxw[15:0] !== IDLE_REPLY) begin
            n_fail++;
            $display("FAIL midreset_next_frame: rx=%h miso=%h expected ffff 0062", rx_data, rxw[15:0]);
        end
    endtask

    task automatic test_tx_load_in_shift;
        set_mode(1'b0, 1'b0);
        exp_rx_q.push_back(16'h0F0F);
        fork
            spi_frame({16'h0F0F, 16'h0000}, 16, 1'b1, rxw);
            begin
                wait_clk(10 * HALF);
                pulse_load(16'h1234);
            end
        join
        n_assert++;
        if (rxw[15:0] !== IDLE_REPLY || rx_data !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL txload_current: miso=%h rx=%h expected 0062 0f0f", rxw[15:0], rx_data);
        end
        exp_rx_q.push_back(16'h7E81);
        spi_frame({16'h7E81, 16'h0000}, 16, 1'b1, rxw);
        n_assert++;
        if (rxw[15:0] !== 16'h1234) begin
            n_fail++;
            $display("FAIL txload_next: miso=%h expected 1234", rxw[15:0]);
        end
        exp_rx_q.push_back(16'h0101);
        spi_frame({16'h0101, 16'h0000}, 16, 1'b1, rxw);
        n_assert++;
        if (rxw[15:0] !== IDLE_REPLY) begin
            n_fail++;
            $display("FAIL txload_revert: miso=%h expected 0062", rxw[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_frame_err();
        test_reset_mid_frame();
        test_tx_load_in_shift();
        wait_clk(10);
        n_assert++;
        if (exp_rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d words outstanding expected 0", exp_rx_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
